// File: rtl/c7bbiu_axi_wr_slv.sv
// c7bbiu_axi_wr_slv: AXI AW/W/B slave that writes each beat into a byte-strobed 64-bit SRAM port.
// One burst in flight; every output is registered.
module c7bbiu_axi_wr_slv #(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              axi_aw_valid,
    output logic              axi_aw_ready,
    input  logic [3:0]        axi_aw_id,
    input  logic [31:0]       axi_aw_addr,
    input  logic [7:0]        axi_aw_len,
    input  logic [2:0]        axi_aw_size,
    input  logic [1:0]        axi_aw_burst,
    input  logic              axi_w_valid,
    output logic              axi_w_ready,
    input  logic [63:0]       axi_w_data,
    input  logic [7:0]        axi_w_strb,
    input  logic              axi_w_last,
    output logic              axi_b_valid,
    input  logic              axi_b_ready,
    output logic [3:0]        axi_b_id,
    output logic [1:0]        axi_b_resp,
    output logic              mem_wr_en,
    output logic [MEM_AW-1:0] mem_wr_addr,
    output logic [63:0]       mem_wr_data,
    output logic [7:0]        mem_wr_strb
);
    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t            state, state_n;
    logic              aw_ready_n, w_ready_n, b_valid_n, mem_wr_en_n, err, err_n;
    logic [3:0]        b_id_n, id, id_n;
    logic [1:0]        b_resp_n, burst, burst_n;
    logic [MEM_AW-1:0] mem_wr_addr_n;
    logic [63:0]       mem_wr_data_n;
    logic [7:0]        mem_wr_strb_n, len, len_n, beat_cnt, beat_cnt_n;
    logic [31:0]       cur_addr, cur_addr_n;
    logic [2:0]        size, size_n;
    logic              oor, beat_err;

    assign oor      = cur_addr[31:MEM_AW+3] != BASE_ADDR[31:MEM_AW+3];
    assign beat_err = err | oor | (axi_w_last != (beat_cnt == len));

    always_comb begin
        state_n       = state;
        aw_ready_n    = axi_aw_ready;
        w_ready_n     = axi_w_ready;
        b_valid_n     = axi_b_valid;
        b_id_n        = axi_b_id;
        b_resp_n      = axi_b_resp;
        mem_wr_en_n   = 1'b0;
        mem_wr_addr_n = mem_wr_addr;
        mem_wr_data_n = mem_wr_data;
        mem_wr_strb_n = mem_wr_strb;
        id_n          = id;
        cur_addr_n    = cur_addr;
        len_n         = len;
        size_n        = size;
        burst_n       = burst;
        beat_cnt_n    = beat_cnt;
        err_n         = err;
        unique case (state)
            IDLE: begin
                aw_ready_n = 1'b1;
                if (axi_aw_valid && axi_aw_ready) begin
                    id_n       = axi_aw_id;
                    cur_addr_n = axi_aw_addr;
                    len_n      = axi_aw_len;
                    size_n     = axi_aw_size;
                    burst_n    = axi_aw_burst;
                    beat_cnt_n = 8'd0;
                    err_n      = axi_aw_burst[1] | (axi_aw_size > 3'd3);
                    aw_ready_n = 1'b0;
                    w_ready_n  = 1'b1;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (axi_w_valid && axi_w_ready) begin
                    // Write uses the error state from before this beat; the beat itself may set err.
                    mem_wr_en_n   = !err && !oor;
                    mem_wr_addr_n = cur_addr[MEM_AW+2:3];
                    mem_wr_data_n = axi_w_data;
                    mem_wr_strb_n = axi_w_strb;
                    cur_addr_n    = (burst == 2'b01) ? cur_addr + (32'd1 << size) : cur_addr;
                    beat_cnt_n    = beat_cnt + 8'd1;
                    err_n         = beat_err;
                    if (axi_w_last) begin
                        w_ready_n = 1'b0;
                        b_valid_n = 1'b1;
                        b_id_n    = id;
                        b_resp_n  = beat_err ? 2'b10 : 2'b00;
                        state_n   = RESP;
                    end
                end
            end
            RESP: begin
                if (axi_b_ready) begin
                    b_valid_n  = 1'b0;
                    aw_ready_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            axi_aw_ready <= 1'b0;
            axi_w_ready  <= 1'b0;
            axi_b_valid  <= 1'b0;
            axi_b_id     <= '0;
            axi_b_resp   <= '0;
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            mem_wr_strb  <= '0;
            id           <= '0;
            cur_addr     <= '0;
            len          <= '0;
            size         <= '0;
            burst        <= '0;
            beat_cnt     <= '0;
            err          <= 1'b0;
        end else begin
            state        <= state_n;
            axi_aw_ready <= aw_ready_n;
            axi_w_ready  <= w_ready_n;
            axi_b_valid  <= b_valid_n;
            axi_b_id     <= b_id_n;
            axi_b_resp   <= b_resp_n;
            mem_wr_en    <= mem_wr_en_n;
            mem_wr_addr  <= mem_wr_addr_n;
            mem_wr_data  <= mem_wr_data_n;
            mem_wr_strb  <= mem_wr_strb_n;
            id           <= id_n;
            cur_addr     <= cur_addr_n;
            len          <= len_n;
            size         <= size_n;
            burst        <= burst_n;
            beat_cnt     <= beat_cnt_n;
            err          <= err_n;
        end
    end
endmodule

// File: tb/tb_c7bbiu_axi_wr_slv.sv
// tb_c7bbiu_axi_wr_slv: table of directed write bursts with hand-computed SRAM writes and B responses,
// plus sequences for a stalled B channel and a reset mid-burst.
module tb_c7bbiu_axi_wr_slv;
    logic        clk = 1'b0, reset = 1'b1;
    logic        axi_aw_valid = 1'b0, axi_aw_ready;
    logic [3:0]  axi_aw_id = '0;
    logic [31:0] axi_aw_addr = '0;
    logic [7:0]  axi_aw_len = '0;
    logic [2:0]  axi_aw_size = '0;
    logic [1:0]  axi_aw_burst = '0;
    logic        axi_w_valid = 1'b0, axi_w_ready;
    logic [63:0] axi_w_data = '0;
    logic [7:0]  axi_w_strb = '0;
    logic        axi_w_last = 1'b0;
    logic        axi_b_valid, axi_b_ready = 1'b1;
    logic [3:0]  axi_b_id;
    logic [1:0]  axi_b_resp;
    logic        mem_wr_en;
    logic [11:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_wr_strb;

    c7bbiu_axi_wr_slv #(.MEM_AW(12), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_id(axi_aw_id),
        .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
        .axi_aw_burst(axi_aw_burst), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
        .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_id(axi_b_id),
        .axi_b_resp(axi_b_resp), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        int          nbeats;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [1:0]  resp;
        int          nwr;
        logic [11:0] first;
        logic [11:0] last;
    } vec_t;

    typedef struct packed {
        logic [11:0] a;
        logic [63:0] d;
        logic [7:0]  s;
    } wr_t;

    wr_t  wq[$];
    vec_t v[11];
    int   errors = 0, checks = 0;

    always @(negedge clk) if (mem_wr_en) wq.push_back({mem_wr_addr, mem_wr_data, mem_wr_strb});

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {axi_aw_ready, axi_w_ready, axi_b_valid, axi_b_id, axi_b_resp,
                mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_strb};
    endfunction

    task automatic run_burst(input vec_t t, input int hold);
        int n, bad;
        wq.delete();
        @(negedge clk);
        axi_aw_valid = 1'b1; axi_aw_addr = t.addr; axi_aw_len = t.len;
        axi_aw_size = t.size; axi_aw_burst = t.burst; axi_aw_id = t.id;
        n = 0;
        while (!axi_aw_ready && n < 20) begin @(negedge clk); n++; end
        chk("aw_handshake", n < 20, 1);
        @(negedge clk);
        axi_aw_valid = 1'b0;
        for (int i = 0; i < t.nbeats; i++) begin
            axi_w_valid = 1'b1; axi_w_data = t.data + 64'(i); axi_w_strb = t.strb;
            axi_w_last = (i == t.nbeats - 1);
            n = 0;
            while (!axi_w_ready && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) chk("w_handshake", 0, 1);
            @(negedge clk);
        end
        axi_w_valid = 1'b0; axi_w_last = 1'b0;
        axi_b_ready = (hold == 0);
        n = 0;
        while (!axi_b_valid && n < 20) begin @(negedge clk); n++; end
        chk("b_valid_seen", n < 20, 1);
        chk("b_id", axi_b_id, t.id);
        chk("b_resp", axi_b_resp, t.resp);
        if (hold > 0) begin
            bad = 0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!axi_b_valid || axi_b_id !== t.id || axi_b_resp !== t.resp || axi_aw_ready) bad++;
            end
            chk("b_stall_stable", bad, 0);
            axi_b_ready = 1'b1;
        end
        @(negedge clk);
        chk("b_valid_drop", axi_b_valid, 0);
        chk("aw_ready_back", axi_aw_ready, 1);
        chk("wr_count", wq.size(), t.nwr);
        if (t.nwr > 0) begin
            chk("wr_first_addr", wq[0].a, t.first);
            chk("wr_last_addr", wq[wq.size()-1].a, t.last);
            chk("wr_first_data", wq[0].d, t.data);
            chk("wr_first_strb", wq[0].s, t.strb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vec_t t;
        v[0]  = '{32'h10,    8'd0, 3'd2, 2'b01, 4'd3,  1, 8'h0F, 64'h1122334455667788, 2'b00, 1, 12'h002, 12'h002};
        v[1]  = '{32'h100,   8'd3, 3'd3, 2'b01, 4'd5,  4, 8'hFF, 64'hA000000000000000, 2'b00, 4, 12'h020, 12'h023};
        v[2]  = '{32'h10000, 8'd0, 3'd3, 2'b01, 4'd1,  1, 8'hFF, 64'h0000000000000011, 2'b10, 0, 12'h000, 12'h000};
        v[3]  = '{32'h40,    8'd1, 3'd3, 2'b10, 4'd2,  2, 8'hFF, 64'h0000000000000022, 2'b10, 0, 12'h000, 12'h000};
        v[4]  = '{32'h200,   8'd3, 3'd3, 2'b01, 4'd4,  1, 8'h3C, 64'h0000000000000033, 2'b10, 1, 12'h040, 12'h040};
        v[5]  = '{32'h308,   8'd2, 3'd3, 2'b00, 4'd6,  3, 8'hF0, 64'h0000000000000044, 2'b00, 3, 12'h061, 12'h061};
        v[6]  = '{32'h20,    8'd0, 3'd4, 2'b01, 4'd7,  1, 8'hFF, 64'h0000000000000055, 2'b10, 0, 12'h000, 12'h000};
        v[7]  = '{32'h20,    8'd0, 3'd3, 2'b11, 4'd8,  1, 8'hFF, 64'h0000000000000066, 2'b10, 0, 12'h000, 12'h000};
        v[8]  = '{32'h1D,    8'd2, 3'd0, 2'b01, 4'd9,  3, 8'h20, 64'h0000000000000077, 2'b00, 3, 12'h003, 12'h003};
        v[9]  = '{32'h7FF8,  8'd1, 3'd3, 2'b01, 4'd10, 2, 8'hFF, 64'h0000000000000088, 2'b10, 1, 12'hFFF, 12'hFFF};
        v[10] = '{32'h400,   8'd1, 3'd3, 2'b01, 4'd11, 3, 8'hFF, 64'h0000000000000099, 2'b10, 2, 12'h080, 12'h081};

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        reset = 1'b0;
        chk("aw_ready_reset_release", axi_aw_ready, 0);
        @(negedge clk);
        chk("aw_ready_first_cycle", axi_aw_ready, 1);

        for (int i = 0; i < 11; i++) run_burst(v[i], 0);

        t = v[0]; t.id = 4'd13; t.addr = 32'h18; t.first = 12'h003; t.last = 12'h003;
        run_burst(t, 5);
        run_burst(v[1], 0);

        @(negedge clk);
        axi_aw_valid = 1'b1; axi_aw_addr = 32'h500; axi_aw_len = 8'd3;
        axi_aw_size = 3'd3; axi_aw_burst = 2'b01; axi_aw_id = 4'd12;
        @(negedge clk);
        axi_aw_valid = 1'b0;
        axi_w_valid = 1'b1; axi_w_data = 64'h55; axi_w_strb = 8'hFF; axi_w_last = 1'b0;
        repeat (2) @(negedge clk);
        axi_w_valid = 1'b0;
        chk("mid_burst_write_pending", mem_wr_en, 1);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", all_outs(), 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (axi_b_valid || axi_w_ready) bad++;
        end
        chk("no_b_after_reset", bad, 0);
        t = v[1]; t.id = 4'd14;
        run_burst(t, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
